// File: rtl/axi_dma_burst_splitter.sv
// axi_dma_burst_splitter: splits 1D DMA transfers into AXI-legal paired read/write chunk requests
// Ports:
//   clk_i, rst_i                                 clock, asynchronous active-high reset
//   burst_*_i, burst_valid_i / burst_ready_o     transfer request: src, dst, byte count, id, caches
//   rd_*_o, rd_valid_o / rd_ready_i              AR descriptor plus R realignment (offset, tailer, shift)
//   wr_*_o, wr_valid_o / wr_ready_i              AW descriptor plus W offset, tailer, beat count
//   busy_o                                       transfer in progress
module axi_dma_burst_splitter #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int IdWidth   = 4,
    parameter int MaxBeats  = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] burst_src_i,
    input  logic [AddrWidth-1:0] burst_dst_i,
    input  logic [AddrWidth-1:0] burst_num_bytes_i,
    input  logic [IdWidth-1:0]   burst_id_i,
    input  logic [3:0]           burst_cache_src_i,
    input  logic [3:0]           burst_cache_dst_i,
    input  logic                 burst_valid_i,
    output logic                 burst_ready_o,
    output logic [IdWidth-1:0]   rd_id_o,
    output logic [AddrWidth-1:0] rd_addr_o,
    output logic [7:0]           rd_len_o,
    output logic [2:0]           rd_size_o,
    output logic [1:0]           rd_burst_o,
    output logic [3:0]           rd_cache_o,
    output logic                 rd_last_o,
    output logic [$clog2(DataWidth/8)-1:0] rd_offset_o,
    output logic [$clog2(DataWidth/8)-1:0] rd_tailer_o,
    output logic [$clog2(DataWidth/8)-1:0] rd_shift_o,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [IdWidth-1:0]   wr_id_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic [7:0]           wr_len_o,
    output logic [2:0]           wr_size_o,
    output logic [1:0]           wr_burst_o,
    output logic [3:0]           wr_cache_o,
    output logic                 wr_last_o,
    output logic [$clog2(DataWidth/8)-1:0] wr_offset_o,
    output logic [$clog2(DataWidth/8)-1:0] wr_tailer_o,
    output logic [7:0]           wr_num_beats_o,
    output logic                 wr_is_single_o,
    output logic                 wr_valid_o,
    input  logic                 wr_ready_i,
    output logic                 busy_o
);
    localparam int StrbW   = DataWidth / 8;
    localparam int OffW    = $clog2(StrbW);
    localparam int SizeLog = $clog2(StrbW);
    localparam logic [AddrWidth-1:0] PageB  = AddrWidth'(4096);
    localparam logic [AddrWidth-1:0] BurstB = AddrWidth'(MaxBeats * StrbW);

    typedef enum logic {IDLE, SPLIT} state_t;

    state_t               r_state;
    logic [AddrWidth-1:0] r_src;
    logic [AddrWidth-1:0] r_dst;
    logic [AddrWidth-1:0] r_rem;
    logic [IdWidth-1:0]   r_id;
    logic [3:0]           r_cache_src;
    logic [3:0]           r_cache_dst;
    logic                 r_rd_sent;
    logic                 r_wr_sent;

    logic [AddrWidth-1:0] w_rd_off;
    logic [AddrWidth-1:0] w_wr_off;
    logic [AddrWidth-1:0] w_lim_src;
    logic [AddrWidth-1:0] w_lim_dst;
    logic [AddrWidth-1:0] w_lim;
    logic [AddrWidth-1:0] w_cs;
    logic                 w_busy;
    logic                 w_rd_fire;
    logic                 w_wr_fire;
    logic                 w_done;

    assign w_busy   = r_state == SPLIT;
    assign w_rd_off = AddrWidth'(r_src[OffW-1:0]);
    assign w_wr_off = AddrWidth'(r_dst[OffW-1:0]);

    // Each side may run to the nearer of its 4 KiB page end and the MaxBeats window
    // measured from its beat-aligned start; the chunk is the tightest of both sides.
    assign w_lim_src = (PageB - AddrWidth'(r_src[11:0]) < BurstB - w_rd_off) ?
                       PageB - AddrWidth'(r_src[11:0]) : BurstB - w_rd_off;
    assign w_lim_dst = (PageB - AddrWidth'(r_dst[11:0]) < BurstB - w_wr_off) ?
                       PageB - AddrWidth'(r_dst[11:0]) : BurstB - w_wr_off;
    assign w_lim     = (w_lim_src < w_lim_dst) ? w_lim_src : w_lim_dst;
    assign w_cs      = (r_rem < w_lim) ? r_rem : w_lim;

    assign w_rd_fire = rd_valid_o & rd_ready_i;
    assign w_wr_fire = wr_valid_o & wr_ready_i;
    assign w_done    = w_busy & (r_rd_sent | w_rd_fire) & (r_wr_sent | w_wr_fire);

    assign burst_ready_o = ~w_busy;
    assign busy_o        = w_busy;

    // Beat count uses (offset + cs - 1) >> OffW, which equals ceil((offset + cs) / StrbW) - 1
    // for any non-empty chunk; outside a transfer the descriptor reads as zero.
    assign rd_id_o     = r_id;
    assign rd_addr_o   = r_src;
    assign rd_len_o    = w_busy ? 8'((w_rd_off + w_cs - AddrWidth'(1)) >> OffW) : 8'd0;
    assign rd_size_o   = 3'(SizeLog);
    assign rd_burst_o  = 2'b01;
    assign rd_cache_o  = r_cache_src;
    assign rd_last_o   = w_busy & (w_cs == r_rem);
    assign rd_offset_o = r_src[OffW-1:0];
    assign rd_tailer_o = OffW'(w_rd_off + w_cs);
    assign rd_shift_o  = OffW'(r_src - r_dst);
    assign rd_valid_o  = w_busy & ~r_rd_sent;

    assign wr_id_o        = r_id;
    assign wr_addr_o      = r_dst;
    assign wr_len_o       = w_busy ? 8'((w_wr_off + w_cs - AddrWidth'(1)) >> OffW) : 8'd0;
    assign wr_size_o      = 3'(SizeLog);
    assign wr_burst_o     = 2'b01;
    assign wr_cache_o     = r_cache_dst;
    assign wr_last_o      = rd_last_o;
    assign wr_offset_o    = r_dst[OffW-1:0];
    assign wr_tailer_o    = OffW'(w_wr_off + w_cs);
    assign wr_num_beats_o = wr_len_o;
    assign wr_is_single_o = w_busy & (wr_len_o == 8'd0);
    assign wr_valid_o     = w_busy & ~r_wr_sent;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_src       <= '0;
            r_dst       <= '0;
            r_rem       <= '0;
            r_id        <= '0;
            r_cache_src <= '0;
            r_cache_dst <= '0;
            r_rd_sent   <= 1'b0;
            r_wr_sent   <= 1'b0;
        end else if (r_state == IDLE) begin
            // A zero-length request is consumed here without leaving IDLE.
            if (burst_valid_i && burst_num_bytes_i != '0) begin
                r_state     <= SPLIT;
                r_src       <= burst_src_i;
                r_dst       <= burst_dst_i;
                r_rem       <= burst_num_bytes_i;
                r_id        <= burst_id_i;
                r_cache_src <= burst_cache_src_i;
                r_cache_dst <= burst_cache_dst_i;
            end
        end else if (w_done) begin
            r_src     <= r_src + w_cs;
            r_dst     <= r_dst + w_cs;
            r_rem     <= r_rem - w_cs;
            r_rd_sent <= 1'b0;
            r_wr_sent <= 1'b0;
            if (rd_last_o)
                r_state <= IDLE;
        end else begin
            r_rd_sent <= r_rd_sent | w_rd_fire;
            r_wr_sent <= r_wr_sent | w_wr_fire;
        end
    end
endmodule

// File: tb/tb_axi_dma_burst_splitter.sv
// tb_axi_dma_burst_splitter: checks the burst splitter against a chunk-list model, vector table and handshake corner cases
module tb_axi_dma_burst_splitter;
    typedef struct {
        logic [63:0] s;
        logic [63:0] d;
        logic [63:0] c;
        bit          last;
    } chunk_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  off;
        logic [2:0]  tail;
        logic [2:0]  shift;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  cache;
        logic [2:0]  size;
        logic [1:0]  burst;
    } rd_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  off;
        logic [2:0]  tail;
        logic [7:0]  nb;
        logic        single;
        logic        last;
        logic [3:0]  id;
        logic [3:0]  cache;
        logic [2:0]  size;
        logic [1:0]  burst;
    } wr_t;

    typedef struct {
        logic [63:0] s;
        logic [63:0] d;
        logic [63:0] n;
        int          inst;
        int          nch;
        logic [7:0]  rl0;
        logic [7:0]  rln;
        logic [7:0]  wl0;
        logic [2:0]  ro;
        logic [2:0]  rt;
        logic [2:0]  wo;
        logic [2:0]  wt;
        logic [2:0]  sh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] src = '0;
    logic [63:0] dst = '0;
    logic [63:0] nb = '0;
    logic [3:0]  id = '0;
    logic [3:0]  c_src = '0;
    logic [3:0]  c_dst = '0;
    logic        bv [2] = '{1'b0, 1'b0};
    logic        rd_rdy = 1'b1;
    logic        wr_rdy = 1'b1;

    logic        b_ready [2];
    logic        rd_valid [2];
    logic        wr_valid [2];
    logic        busy [2];
    logic        rd_last [2];
    logic        wr_last [2];
    logic        wr_single [2];
    logic [63:0] rd_addr [2];
    logic [63:0] wr_addr [2];
    logic [7:0]  rd_len [2];
    logic [7:0]  wr_len [2];
    logic [7:0]  wr_nb [2];
    logic [2:0]  rd_size [2];
    logic [2:0]  wr_size [2];
    logic [2:0]  rd_off [2];
    logic [2:0]  rd_tail [2];
    logic [2:0]  rd_shift [2];
    logic [2:0]  wr_off [2];
    logic [2:0]  wr_tail [2];
    logic [1:0]  rd_burst [2];
    logic [1:0]  wr_burst [2];
    logic [3:0]  rd_id [2];
    logic [3:0]  wr_id [2];
    logic [3:0]  rd_cache [2];
    logic [3:0]  wr_cache [2];

    int     n_cmp = 0;
    int     n_err = 0;
    int     sel = 0;
    int     rd_cnt = 0;
    int     wr_cnt = 0;
    chunk_t mq[$];
    rd_t    rd_log[$];
    wr_t    wr_log[$];
    logic [3:0] exp_id, exp_cs, exp_cd;
    logic   rd_hold = 1'b0;
    logic   wr_hold = 1'b0;
    rd_t    rd_prev;
    wr_t    wr_prev;
    vec_t   tv [5];

    always #5 clk = ~clk;

    // Instance 0 uses the default 256-beat limit, instance 1 a 4-beat limit.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi_dma_burst_splitter #(
            .AddrWidth(64), .DataWidth(64), .IdWidth(4), .MaxBeats(g == 0 ? 256 : 4)
        ) u_dut (
            .clk_i(clk), .rst_i(rst),
            .burst_src_i(src), .burst_dst_i(dst), .burst_num_bytes_i(nb), .burst_id_i(id),
            .burst_cache_src_i(c_src), .burst_cache_dst_i(c_dst),
            .burst_valid_i(bv[g]), .burst_ready_o(b_ready[g]),
            .rd_id_o(rd_id[g]), .rd_addr_o(rd_addr[g]), .rd_len_o(rd_len[g]), .rd_size_o(rd_size[g]),
            .rd_burst_o(rd_burst[g]), .rd_cache_o(rd_cache[g]), .rd_last_o(rd_last[g]),
            .rd_offset_o(rd_off[g]), .rd_tailer_o(rd_tail[g]), .rd_shift_o(rd_shift[g]),
            .rd_valid_o(rd_valid[g]), .rd_ready_i(rd_rdy),
            .wr_id_o(wr_id[g]), .wr_addr_o(wr_addr[g]), .wr_len_o(wr_len[g]), .wr_size_o(wr_size[g]),
            .wr_burst_o(wr_burst[g]), .wr_cache_o(wr_cache[g]), .wr_last_o(wr_last[g]),
            .wr_offset_o(wr_off[g]), .wr_tailer_o(wr_tail[g]),
            .wr_num_beats_o(wr_nb[g]), .wr_is_single_o(wr_single[g]),
            .wr_valid_o(wr_valid[g]), .wr_ready_i(wr_rdy),
            .busy_o(busy[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mn(input logic [63:0] a, input logic [63:0] b);
        return (a < b) ? a : b;
    endfunction

    // Reference: walk the transfer, each chunk limited by remaining bytes, page ends and burst windows.
    task automatic build(input logic [63:0] s, input logic [63:0] d, input logic [63:0] n, input int mb);
        logic [63:0] c;
        mq.delete();
        while (n != 0) begin
            c = mn(n, mn(mn(4096 - s % 4096, mb * 8 - s % 8), mn(4096 - d % 4096, mb * 8 - d % 8)));
            mq.push_back('{s, d, c, c == n});
            s = s + c;
            d = d + c;
            n = n - c;
        end
    endtask

    function automatic rd_t exp_rd(input chunk_t k);
        logic [63:0] o;
        o = k.s % 8;
        return {k.s, 8'((o + k.c + 7) / 8 - 1), 3'(o), 3'((o + k.c) % 8), 3'((k.s - k.d) % 8),
                k.last, exp_id, exp_cs, 3'd3, 2'b01};
    endfunction

    function automatic wr_t exp_wr(input chunk_t k);
        logic [63:0] o;
        logic [7:0]  l;
        o = k.d % 8;
        l = 8'((o + k.c + 7) / 8 - 1);
        return {k.d, l, 3'(o), 3'((o + k.c) % 8), l, l == 8'd0, k.last, exp_id, exp_cd, 3'd3, 2'b01};
    endfunction

    always @(negedge clk) begin
        rd_t a_rd;
        wr_t a_wr;
        logic rf, wf;
        int rc, wc;
        if (rst) begin
            rd_hold = 1'b0;
            wr_hold = 1'b0;
        end else begin
            a_rd = {rd_addr[sel], rd_len[sel], rd_off[sel], rd_tail[sel], rd_shift[sel], rd_last[sel],
                    rd_id[sel], rd_cache[sel], rd_size[sel], rd_burst[sel]};
            a_wr = {wr_addr[sel], wr_len[sel], wr_off[sel], wr_tail[sel], wr_nb[sel], wr_single[sel],
                    wr_last[sel], wr_id[sel], wr_cache[sel], wr_size[sel], wr_burst[sel]};
            rf = rd_valid[sel] && rd_rdy;
            wf = wr_valid[sel] && wr_rdy;
            rc = rd_cnt;
            wc = wr_cnt;
            if (rd_hold) chk("rd_hold", {rd_valid[sel], a_rd}, {1'b1, rd_prev});
            if (wr_hold) chk("wr_hold", {wr_valid[sel], a_wr}, {1'b1, wr_prev});
            if (rf) begin
                if (rc >= mq.size()) chk("rd_extra", rc, mq.size());
                else begin
                    chk("rd_desc", a_rd, exp_rd(mq[rc]));
                    chk("rd_order", wc >= rc, 1'b1);
                end
                rd_log.push_back(a_rd);
                rd_cnt++;
            end
            if (wf) begin
                if (wc >= mq.size()) chk("wr_extra", wc, mq.size());
                else begin
                    chk("wr_desc", a_wr, exp_wr(mq[wc]));
                    chk("wr_order", rc >= wc, 1'b1);
                end
                wr_log.push_back(a_wr);
                wr_cnt++;
            end
            rd_hold = rd_valid[sel] && !rd_rdy;
            wr_hold = wr_valid[sel] && !wr_rdy;
            rd_prev = a_rd;
            wr_prev = a_wr;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic start(input int inst, input logic [63:0] s, input logic [63:0] d, input logic [63:0] n,
                         input logic [3:0] i, input logic [3:0] cs, input logic [3:0] cd);
        sel = inst;
        build(s, d, n, inst == 0 ? 256 : 4);
        exp_id = i;
        exp_cs = cs;
        exp_cd = cd;
        rd_cnt = 0;
        wr_cnt = 0;
        rd_log.delete();
        wr_log.delete();
        chk("accept_ready", b_ready[inst], 1'b1);
        src = s;
        dst = d;
        nb = n;
        id = i;
        c_src = cs;
        c_dst = cd;
        bv[inst] = 1'b1;
        @(posedge clk);
        #1;
        bv[inst] = 1'b0;
        src = 64'($urandom);
        nb = 64'($urandom);
    endtask

    task automatic finish(input int budget, input bit rnd, output int cyc);
        cyc = 0;
        while ((rd_cnt < mq.size() || wr_cnt < mq.size()) && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rnd) begin
                rd_rdy = $urandom_range(0, 3) != 0;
                wr_rdy = $urandom_range(0, 3) != 0;
            end
        end
        chk("done", {32'(rd_cnt), 32'(wr_cnt), b_ready[sel], busy[sel]},
            {32'(mq.size()), 32'(mq.size()), 1'b1, 1'b0});
        rd_rdy = 1'b1;
        wr_rdy = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, inst;
        logic [63:0] s, d, n;
        tv[0] = '{64'h1000, 64'h2000, 64'd64,  0, 1, 8'd7, 8'd7, 8'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        tv[1] = '{64'h0FF8, 64'h3000, 64'd16,  0, 2, 8'd0, 8'd0, 8'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        tv[2] = '{64'h1003, 64'h2005, 64'd10,  0, 1, 8'd1, 8'd1, 8'd1, 3'd3, 3'd5, 3'd5, 3'd7, 3'd6};
        tv[3] = '{64'h0000, 64'h0100, 64'd100, 1, 4, 8'd3, 8'd0, 8'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        tv[4] = '{64'h1000, 64'h2000, 64'd64,  1, 2, 8'd3, 8'd3, 8'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++)
            chk("reset_state", {b_ready[k], rd_valid[k], wr_valid[k], busy[k], rd_addr[k], rd_len[k]},
                {1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 8'd0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            start(tv[i].inst, tv[i].s, tv[i].d, tv[i].n, 4'h5, 4'h3, 4'hA);
            finish(50, 1'b0, cyc);
            chk("vec", {32'(rd_log.size()), rd_log[0].len, rd_log[$].len, wr_log[0].len, rd_log[0].off,
                        rd_log[0].tail, wr_log[0].off, wr_log[0].tail, rd_log[0].shift},
                {32'(tv[i].nch), tv[i].rl0, tv[i].rln, tv[i].wl0, tv[i].ro, tv[i].rt, tv[i].wo,
                 tv[i].wt, tv[i].sh});
            chk("throughput", cyc, tv[i].nch);
        end

        rd_rdy = 1'b1;
        wr_rdy = 1'b0;
        start(0, 64'h0FF8, 64'h3000, 64'd16, 4'h2, 4'h1, 4'h2);
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("skew", {rd_valid[0], wr_valid[0], wr_addr[0], 32'(rd_cnt), 32'(wr_cnt)},
                {1'b0, 1'b1, 64'h3000, 32'd1, 32'd0});
            @(posedge clk);
            #1;
        end
        wr_rdy = 1'b1;
        finish(20, 1'b0, cyc);

        start(0, 64'h5000, 64'h6000, 64'd0, 4'h1, 4'h1, 4'h1);
        for (int k = 0; k < 4; k++) begin
            chk("zero_len", {b_ready[0], rd_valid[0], wr_valid[0], busy[0]}, 4'b1000);
            @(posedge clk);
            #1;
        end

        start(1, 64'h0, 64'h100, 64'd100, 4'h7, 4'h6, 4'h5);
        @(posedge clk);
        #1;
        chk("pre_rst", {rd_valid[1], rd_addr[1], wr_addr[1]}, {1'b1, 64'd32, 64'h120});
        rst = 1'b1;
        #1;
        chk("rst_mid", {rd_valid[1], wr_valid[1], busy[1], b_ready[1], rd_addr[1], wr_addr[1]},
            {1'b0, 1'b0, 1'b0, 1'b1, 64'd0, 64'd0});
        mq.delete();
        rd_cnt = 0;
        wr_cnt = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst", {rd_valid[1], wr_valid[1], b_ready[1]}, 3'b001);
        end
        start(1, 64'h0FF0, 64'h2004, 64'd70, 4'h9, 4'h8, 4'h7);
        finish(50, 1'b0, cyc);

        for (int t = 0; t < 40; t++) begin
            inst = $urandom_range(0, 1);
            s = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) != 0) s[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
            if ($urandom_range(0, 1) != 0) d[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
            if (t == 0) s = 64'hFFFF_FFFF_FFFF_FFFA;
            n = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 8)) : 64'($urandom_range(1, 600));
            if (t % 10 == 5) n = 64'($urandom_range(3000, 6000));
            rd_rdy = $urandom_range(0, 3) != 0;
            wr_rdy = $urandom_range(0, 3) != 0;
            start(inst, s, d, n, 4'($urandom), 4'($urandom), 4'($urandom));
            finish(30 * mq.size() + 40, 1'b1, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_dma_burst_splitter.md
Name: axi_dma_burst_splitter

Overview:
Front-end stage that feeds the DMA data mover. It accepts one 1D transfer (src, dst, byte count) per handshake and splits it into AXI-legal chunks. Each chunk is emitted as a paired read request (AR descriptor plus R realignment descriptor) and write request (AW descriptor plus W descriptor). The read and write requests of a chunk describe identical byte ranges, and neither request of chunk N+1 is issued before both requests of chunk N have been accepted.

Parameters:
AddrWidth, 64, address and byte-count width
DataWidth, 64, AXI data width; StrbW=DataWidth/8, OffW=log2(StrbW), SizeLog=log2(StrbW)
IdWidth, 4, AXI ID width
MaxBeats, 256, max beats per burst; power of two, 1..256

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
burst_src_i  in  AddrWidth  source byte address
burst_dst_i  in  AddrWidth  destination byte address
burst_num_bytes_i  in  AddrWidth  transfer length in bytes
burst_id_i  in  IdWidth  AXI id for AR and AW
burst_cache_src_i / burst_cache_dst_i  in  4 each  AR / AW cache
burst_valid_i / burst_ready_o  in / out  1 each  transfer handshake
rd_id_o, rd_addr_o, rd_len_o, rd_size_o, rd_burst_o, rd_cache_o, rd_last_o  out  IdWidth/AddrWidth/8/3/2/4/1  AR descriptor
rd_offset_o, rd_tailer_o, rd_shift_o  out  OffW each  R realignment descriptor
rd_valid_o / rd_ready_i  out / in  1 each  read request handshake
wr_id_o, wr_addr_o, wr_len_o, wr_size_o, wr_burst_o, wr_cache_o, wr_last_o  out  as rd_*  AW descriptor
wr_offset_o, wr_tailer_o  out  OffW each  W offset and tailer
wr_num_beats_o, wr_is_single_o  out  8 / 1  W beat count, single-beat flag
wr_valid_o / wr_ready_i  out / in  1 each  write request handshake
busy_o  out  1  transfer in progress

Behaviour:
- Reset: FSM=IDLE, burst_ready_o=1, rd_valid_o=0, wr_valid_o=0, busy_o=0. Registered descriptors clear to 0; sent flags clear.
- FSM IDLE: burst_ready_o=1.
  - Accept with num_bytes>0: register src, dst, remaining=num_bytes, id, caches; go to SPLIT.
  - Accept with num_bytes==0: consumed, nothing emitted, stay IDLE.
- FSM SPLIT: burst_ready_o=0, busy_o=1.
- Chunk size, all combinational from registers:
  - cs = min(remaining, limS, limD)
  - limX = min(4096 - X[11:0], MaxBeats*StrbW - (X mod StrbW))
- Read fields:
  - rd_addr=src, rd_offset=src[OffW-1:0]
  - rd_tailer=(rd_offset+cs) mod StrbW (0 means full last beat)
  - rd_len=ceil((rd_offset+cs)/StrbW)-1
  - rd_shift=(src-dst) mod StrbW
  - rd_size=SizeLog, rd_burst=2'b01 (INCR)
  - rd_last=(cs==remaining)
- Write fields:
  - wr_addr=dst, with offset, tailer and len computed from dst in the same way as the read side
  - wr_num_beats=wr_len, wr_is_single=(wr_len==0)
  - wr_last=rd_last
- Handshakes:
  - rd_valid_o=SPLIT & ~rd_sent; wr_valid_o=SPLIT & ~wr_sent.
  - Valid, once high, holds with stable payload until its ready.
  - A fire before the partner fires sets rd_sent or wr_sent.
  - Chunk completes in the cycle where (rd_sent|rd fire) & (wr_sent|wr fire). Same-cycle fire on both is allowed.
- On chunk completion: src+=cs, dst+=cs, remaining-=cs, sent flags clear. If the chunk was last, go to IDLE, else next chunk is presented in the next cycle.
- Throughput: one chunk per cycle when both readies are held high. New transfer accepted the cycle after the last chunk completes.
- Address arithmetic wraps modulo 2^AddrWidth. The 4 KiB page and MaxBeats rules guarantee len ≤ MaxBeats-1 and no page crossing.
- Reset asserted mid-transfer: immediate return to reset state. The partial transfer is discarded; no valid glitch after deassert.

Test Plan:
1. Aligned: src=0x1000, dst=0x2000, n=64 (DataWidth=64) -> one pair; len=7, offsets=0, tailers=0, shift=0, last=1, num_beats=7, is_single=0.
2. Page cross: src=0x0FF8, dst=0x3000, n=16 -> two chunks.
   - Chunk 1: rd_addr=0x0FF8, wr_addr=0x3000, len=0, is_single=1.
   - Chunk 2: rd_addr=0x1000, wr_addr=0x3008, last=1.
3. Misaligned: src=0x1003, dst=0x2005, n=10 -> rd offset=3, rd tailer=5, rd_len=1; wr offset=5, wr tailer=7, wr_len=1; shift=6.
4. MaxBeats=4, src=0, dst=0x100, n=100 -> chunks of 32, 32, 32, 4 bytes; lens 3, 3, 3, 0; only the fourth has last=1.
5. Skewed readies: rd_ready_i=1, wr_ready_i low for 5 cycles -> rd_valid_o drops after 1 cycle, wr payload held stable, next chunk only after wr fire. Then 0-byte request -> burst_ready_o stays 1, no valid emitted.
6. Assert rst_i during chunk 2 of test 4 -> all valids 0, busy_o=0, burst_ready_o=1 the same cycle. A fresh transfer after deassert is split correctly.
